// File: rtl/button_event_decoder.sv
// Turns a debounced button level into press/release/short/long/repeat event pulses plus a wrapping press count.
// Auto-repeat in the LONG state is built only when BUTTON_AUTO_REPEAT_EN is defined.
module button_event_decoder #(
   parameter int LONG_CYCLES   = 50000000,
   parameter int REPEAT_CYCLES = 10000000,
   parameter int CNT_WIDTH     = 27
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       debounced,
   output logic       press_pulse,
   output logic       release_pulse,
   output logic       short_press,
   output logic       long_press,
   output logic       repeat_pulse,
   output logic       held,
   output logic [7:0] press_count
);

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      PRESSED = 2'b01,
      LONG    = 2'b10
   } state_t;

   localparam int CNT_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
   localparam logic [CNT_WIDTH-1:0] LONG_LAST = CNT_WIDTH'(LONG_CYCLES - 1);

   if ((LONG_CYCLES < 2) || (REPEAT_CYCLES < 1) || ($clog2(CNT_MAX) > CNT_WIDTH)) begin : g_bad_params
      $error("button_event_decoder: illegal LONG_CYCLES/REPEAT_CYCLES/CNT_WIDTH combination");
   end

   state_t               state_r;
   state_t               state_nxt_s;
   logic [CNT_WIDTH-1:0] hold_cnt_r;
   logic [CNT_WIDTH-1:0] hold_cnt_nxt_s;
   logic                 press_nxt_s;
   logic                 release_nxt_s;
   logic                 short_nxt_s;
   logic                 long_nxt_s;
   logic                 press_r;
   logic                 release_r;
   logic                 short_r;
   logic                 long_r;
   logic                 held_r;
   logic [7:0]           press_count_r;

   // State and hold counter registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r    <= IDLE;
         hold_cnt_r <= {CNT_WIDTH{1'b0}};
      end else begin
         state_r    <= state_nxt_s;
         hold_cnt_r <= hold_cnt_nxt_s;
      end
   end

   // Next-state logic; release is tested before the long threshold so it wins a tie
   always_comb begin
      state_nxt_s    = IDLE;
      hold_cnt_nxt_s = hold_cnt_r;
      case (state_r)
         IDLE: begin
            if (debounced) begin
               state_nxt_s    = PRESSED;
               hold_cnt_nxt_s = {CNT_WIDTH{1'b0}};
            end else begin
               state_nxt_s    = IDLE;
            end
         end
         PRESSED: begin
            if (!debounced) begin
               state_nxt_s    = IDLE;
            end else if (hold_cnt_r == LONG_LAST) begin
               state_nxt_s    = LONG;
            end else begin
               state_nxt_s    = PRESSED;
               hold_cnt_nxt_s = hold_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
         end
         LONG: begin
            state_nxt_s = debounced ? LONG : IDLE;
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Next values of the event pulses
   always_comb begin
      press_nxt_s   = (state_r == IDLE) && debounced;
      release_nxt_s = ((state_r == PRESSED) || (state_r == LONG)) && !debounced;
      short_nxt_s   = (state_r == PRESSED) && !debounced;
      long_nxt_s    = (state_r == PRESSED) && debounced && (hold_cnt_r == LONG_LAST);
   end

   // Registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         press_r       <= 1'b0;
         release_r     <= 1'b0;
         short_r       <= 1'b0;
         long_r        <= 1'b0;
         held_r        <= 1'b0;
         press_count_r <= 8'd0;
      end else begin
         press_r       <= press_nxt_s;
         release_r     <= release_nxt_s;
         short_r       <= short_nxt_s;
         long_r        <= long_nxt_s;
         held_r        <= (state_nxt_s != IDLE);
         press_count_r <= press_nxt_s ? (press_count_r + 8'd1) : press_count_r;
      end
   end

`ifdef BUTTON_AUTO_REPEAT_EN
   localparam logic [CNT_WIDTH-1:0] REPEAT_LAST = CNT_WIDTH'(REPEAT_CYCLES - 1);

   logic [CNT_WIDTH-1:0] rpt_cnt_r;
   logic [CNT_WIDTH-1:0] rpt_cnt_nxt_s;
   logic                 repeat_nxt_s;
   logic                 repeat_r;

   // Repeat counter restarts on entry to LONG and on every repeat pulse
   always_comb begin
      repeat_nxt_s  = (state_r == LONG) && debounced && (rpt_cnt_r == REPEAT_LAST);
      rpt_cnt_nxt_s = rpt_cnt_r;
      case (state_r)
         PRESSED: rpt_cnt_nxt_s = long_nxt_s ? {CNT_WIDTH{1'b0}} : rpt_cnt_r;
         LONG: begin
            if (!debounced) begin
               rpt_cnt_nxt_s = rpt_cnt_r;
            end else if (repeat_nxt_s) begin
               rpt_cnt_nxt_s = {CNT_WIDTH{1'b0}};
            end else begin
               rpt_cnt_nxt_s = rpt_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
         end
         default: rpt_cnt_nxt_s = rpt_cnt_r;
      endcase
   end

   // Repeat counter and pulse registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rpt_cnt_r <= {CNT_WIDTH{1'b0}};
         repeat_r  <= 1'b0;
      end else begin
         rpt_cnt_r <= rpt_cnt_nxt_s;
         repeat_r  <= repeat_nxt_s;
      end
   end

   assign repeat_pulse = repeat_r;
`else
   assign repeat_pulse = 1'b0;
`endif

   assign press_pulse   = press_r;
   assign release_pulse = release_r;
   assign short_press   = short_r;
   assign long_press    = long_r;
   assign held          = held_r;
   assign press_count   = press_count_r;

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed and randomized bench for button_event_decoder, checked against a hold-length model.
module tb_button_event_decoder;

   localparam int LC = 10;
   localparam int RC = 4;
`ifdef BUTTON_AUTO_REPEAT_EN
   localparam bit RPT_EN = 1'b1;
`else
   localparam bit RPT_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset_n;
   logic       debounced;
   logic       press_pulse;
   logic       release_pulse;
   logic       short_press;
   logic       long_press;
   logic       repeat_pulse;
   logic       held;
   logic [7:0] press_count;

   int checks = 0;
   int errors = 0;

   // Model: whether the button is down and how many consecutive high samples it has seen
   bit         m_pressed = 1'b0;
   int         m_len     = 0;
   logic [7:0] m_count   = 8'd0;
   int         n_press   = 0;
   int         n_release = 0;

   button_event_decoder #(
      .LONG_CYCLES  (LC),
      .REPEAT_CYCLES(RC),
      .CNT_WIDTH    (8)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .debounced    (debounced),
      .press_pulse  (press_pulse),
      .release_pulse(release_pulse),
      .short_press  (short_press),
      .long_press   (long_press),
      .repeat_pulse (repeat_pulse),
      .held         (held),
      .press_count  (press_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input logic ep, input logic er, input logic es, input logic el, input logic erp);
      chk("press_pulse",   {7'd0, press_pulse},   {7'd0, ep});
      chk("release_pulse", {7'd0, release_pulse}, {7'd0, er});
      chk("short_press",   {7'd0, short_press},   {7'd0, es});
      chk("long_press",    {7'd0, long_press},    {7'd0, el});
      chk("repeat_pulse",  {7'd0, repeat_pulse},  {7'd0, erp});
      chk("held",          {7'd0, held},          {7'd0, m_pressed});
      chk("press_count",   press_count,           m_count);
   endtask

   // One clock with the given level, then compare against the model
   task automatic step(input logic d);
      logic ep, er, es, el, erp;
      ep = 1'b0; er = 1'b0; es = 1'b0; el = 1'b0; erp = 1'b0;
      debounced = d;
      @(posedge clk);
      if (!m_pressed) begin
         if (d) begin
            ep        = 1'b1;
            m_pressed = 1'b1;
            m_len     = 1;
            m_count   = m_count + 8'd1;
         end
      end else if (!d) begin
         er        = 1'b1;
         es        = (m_len <= LC);
         m_pressed = 1'b0;
      end else begin
         m_len = m_len + 1;
         el    = (m_len == LC + 1);
         erp   = RPT_EN && (m_len > LC + 1) && (((m_len - LC - 1) % RC) == 0);
      end
      #1;
      chk_all(ep, er, es, el, erp);
      if (press_pulse)   n_press++;
      if (release_pulse) n_release++;
   endtask

   task automatic hold_level(input logic d, input int n);
      for (int i = 0; i < n; i++) step(d);
   endtask

   // Assert reset away from the clock edge, check cleared outputs, release after the next falling edge
   task automatic do_reset();
      reset_n   = 1'b0;
      m_pressed = 1'b0;
      m_len     = 0;
      m_count   = 8'd0;
      #1;
      chk_all(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      #1;
      chk_all(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      reset_n = 1'b1;
   endtask

   initial begin
      debounced = 1'b0;
      reset_n   = 1'b0;
      #2;
      do_reset();
      hold_level(1'b0, 2);

      // short press of 5 cycles
      hold_level(1'b1, 5);
      hold_level(1'b0, 3);
      chk("count_after_short", press_count, 8'd1);

      // long hold of 20 cycles, with repeats when enabled
      hold_level(1'b1, 20);
      hold_level(1'b0, 3);

      // release on the same edge as the long threshold
      hold_level(1'b1, LC);
      hold_level(1'b0, 3);

      // single-cycle low between highs counts as release plus new press
      hold_level(1'b1, 3);
      step(1'b0);
      hold_level(1'b1, 3);
      hold_level(1'b0, 2);

      // press_count wrap over 257 presses
      do_reset();
      n_press   = 0;
      n_release = 0;
      for (int i = 0; i < 257; i++) begin
         hold_level(1'b1, 3);
         hold_level(1'b0, 2);
      end
      chk("wrap_count", press_count, 8'd1);
      chk("wrap_press_pulses",   8'(n_press - 256),   8'd1);
      chk("wrap_release_pulses", 8'(n_release - 256), 8'd1);

      // reset in the middle of a long hold with the button still down
      hold_level(1'b1, LC + 5);
      debounced = 1'b1;
      do_reset();
      step(1'b1);
      chk("count_after_reset", press_count, 8'd1);
      hold_level(1'b1, 30);
      hold_level(1'b0, 2);

      // randomized press/release runs
      for (int i = 0; i < 40; i++) begin
         hold_level(1'b1, int'($urandom_range(1, 24)));
         hold_level(1'b0, int'($urandom_range(1, 4)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
